// File: rtl/alarm_ringer_if.sv
// Handshake bundle between the alarm comparator/timebase side and the ringer controller.
interface alarm_ringer_if;
    logic       tick_1hz;
    logic       alarm_on;
    logic       alarm_en;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic       clear_alarm;
    logic [3:0] snooze_left;

    modport master (
        output tick_1hz, alarm_on, alarm_en, stop_btn, snooze_btn,
        input  buzzer, ringing, snoozing, clear_alarm, snooze_left
    );

    modport slave (
        input  tick_1hz, alarm_on, alarm_en, stop_btn, snooze_btn,
        output buzzer, ringing, snoozing, clear_alarm, snooze_left
    );
endinterface

// File: rtl/alarm_ringer_ctrl.sv
// Alarm ring/snooze/stop session controller: drives the buzzer pattern and holds the
// comparator's auto-reset (clear_alarm) for a cooldown after every session.
module alarm_ringer_ctrl #(
    parameter int unsigned RING_TIMEOUT_S   = 60,
    parameter int unsigned SNOOZE_S         = 300,
    parameter int unsigned MAX_SNOOZE       = 3,
    parameter int unsigned COOLDOWN_S       = 2,
    parameter int unsigned BEEP_HALF_PERIOD = 25_000_000
) (
    input logic           clk,
    input logic           rst_n,
    alarm_ringer_if.slave ar_if
);

    localparam int unsigned RING_W = (RING_TIMEOUT_S > 1)   ? $clog2(RING_TIMEOUT_S)   : 1;
    localparam int unsigned SNZ_W  = (SNOOZE_S > 1)         ? $clog2(SNOOZE_S)         : 1;
    localparam int unsigned CD_W   = (COOLDOWN_S > 1)       ? $clog2(COOLDOWN_S)       : 1;
    localparam int unsigned BEEP_W = (BEEP_HALF_PERIOD > 1) ? $clog2(BEEP_HALF_PERIOD) : 1;
    localparam int unsigned SL_W   = 4;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_S - 1);
    localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_S - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF_PERIOD - 1);
    localparam logic [SL_W-1:0]   SL_MAX    = SL_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RING,
        S_SNOOZE,
        S_COOLDOWN
    } state_t;

    state_t            state_q, state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic [SL_W-1:0]   snooze_left_q, snooze_left_d;
    logic              buzzer_q, buzzer_d;
    logic              ringing_q, ringing_d;
    logic              snoozing_q, snoozing_d;
    logic              clear_q, clear_d;
    logic              stop_q, snooze_q;
    logic              stop_edge, snooze_edge;

    assign stop_edge   = ar_if.stop_btn & ~stop_q;
    assign snooze_edge = ar_if.snooze_btn & ~snooze_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            cd_cnt_q      <= '0;
            beep_cnt_q    <= '0;
            snooze_left_q <= SL_MAX;
            buzzer_q      <= 1'b0;
            ringing_q     <= 1'b0;
            snoozing_q    <= 1'b0;
            clear_q       <= 1'b0;
            stop_q        <= 1'b0;
            snooze_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            cd_cnt_q      <= cd_cnt_d;
            beep_cnt_q    <= beep_cnt_d;
            snooze_left_q <= snooze_left_d;
            buzzer_q      <= buzzer_d;
            ringing_q     <= ringing_d;
            snoozing_q    <= snoozing_d;
            clear_q       <= clear_d;
            stop_q        <= ar_if.stop_btn;
            snooze_q      <= ar_if.snooze_btn;
        end
    end

    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        cd_cnt_d      = cd_cnt_q;
        beep_cnt_d    = '0;
        buzzer_d      = 1'b0;
        snooze_left_d = snooze_left_q;

        case (state_q)
            S_IDLE: begin
                if (ar_if.alarm_on && ar_if.alarm_en) begin
                    state_d       = S_RING;
                    snooze_left_d = SL_MAX;
                    ring_cnt_d    = '0;
                    buzzer_d      = 1'b1;
                end
            end
            S_RING: begin
                if (beep_cnt_q == BEEP_LAST) begin
                    beep_cnt_d = '0;
                    buzzer_d   = ~buzzer_q;
                end else begin
                    beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                    buzzer_d   = buzzer_q;
                end
                // Priority: stop > disable > timeout > snooze; a consumed tick is not counted.
                if (stop_edge || !ar_if.alarm_en) begin
                    state_d  = S_COOLDOWN;
                    cd_cnt_d = '0;
                end else if (ar_if.tick_1hz && ring_cnt_q == RING_LAST) begin
                    state_d  = S_COOLDOWN;
                    cd_cnt_d = '0;
                end else if (snooze_edge && snooze_left_q != '0) begin
                    state_d       = S_SNOOZE;
                    snooze_left_d = snooze_left_q - SL_W'(1);
                    snz_cnt_d     = '0;
                end else if (ar_if.tick_1hz) begin
                    ring_cnt_d = ring_cnt_q + RING_W'(1);
                end
            end
            S_SNOOZE: begin
                if (stop_edge || !ar_if.alarm_en) begin
                    state_d  = S_COOLDOWN;
                    cd_cnt_d = '0;
                end else if (ar_if.tick_1hz && snz_cnt_q == SNZ_LAST) begin
                    state_d    = S_RING;
                    ring_cnt_d = '0;
                    buzzer_d   = 1'b1;
                end else if (ar_if.tick_1hz) begin
                    snz_cnt_d = snz_cnt_q + SNZ_W'(1);
                end
            end
            S_COOLDOWN: begin
                if (ar_if.tick_1hz && cd_cnt_q == CD_LAST) begin
                    state_d = S_IDLE;
                end else if (ar_if.tick_1hz) begin
                    cd_cnt_d = cd_cnt_q + CD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Beep pattern only survives while the session stays in (or enters) RING.
        if (state_d != S_RING) begin
            buzzer_d   = 1'b0;
            beep_cnt_d = '0;
        end

        ringing_d  = (state_d == S_RING);
        snoozing_d = (state_d == S_SNOOZE);
        clear_d    = (state_d != S_IDLE);
    end

    assign ar_if.buzzer      = buzzer_q;
    assign ar_if.ringing     = ringing_q;
    assign ar_if.snoozing    = snoozing_q;
    assign ar_if.clear_alarm = clear_q;
    assign ar_if.snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ringer_ctrl.sv
// Randomized bench for alarm_ringer_ctrl against a session-level reference model.
module tb_alarm_ringer_ctrl;

    localparam int RT  = 4;
    localparam int SNZ = 3;
    localparam int MAX = 2;
    localparam int CD  = 2;
    localparam int BHP = 4;
    localparam int N_CYCLES = 4000;

    typedef enum {M_IDLE, M_RING, M_SNOOZE, M_COOL} mphase_t;

    logic clk;
    logic rst_n;
    alarm_ringer_if u_if ();

    alarm_ringer_ctrl #(
        .RING_TIMEOUT_S  (RT),
        .SNOOZE_S        (SNZ),
        .MAX_SNOOZE      (MAX),
        .COOLDOWN_S      (CD),
        .BEEP_HALF_PERIOD(BHP)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ar_if(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: session phase, seconds elapsed in the phase, and the
    // cycle the current ring began (buzzer level derives from elapsed cycles).
    mphase_t m_phase;
    int      m_secs;
    int      m_left;
    longint  m_cyc;
    longint  m_ring_start;
    bit      m_stop_prev, m_snz_prev;

    task automatic model_reset();
        m_phase     = M_IDLE;
        m_secs      = 0;
        m_left      = MAX;
        m_stop_prev = 0;
        m_snz_prev  = 0;
    endtask

    task automatic start_ring();
        m_phase      = M_RING;
        m_secs       = 0;
        m_ring_start = m_cyc;
    endtask

    task automatic model_step(input bit tick, input bit on, input bit en,
                              input bit stop, input bit snz);
        bit stop_ev, snz_ev;
        m_cyc++;
        stop_ev     = stop && !m_stop_prev;
        snz_ev      = snz && !m_snz_prev;
        m_stop_prev = stop;
        m_snz_prev  = snz;
        case (m_phase)
            M_IDLE: if (on && en) begin
                m_left = MAX;
                start_ring();
            end
            M_RING: begin
                if (stop_ev || !en || (tick && m_secs + 1 == RT)) begin
                    m_phase = M_COOL;
                    m_secs  = 0;
                end else if (snz_ev && m_left > 0) begin
                    m_phase = M_SNOOZE;
                    m_left--;
                    m_secs  = 0;
                end else if (tick) m_secs++;
            end
            M_SNOOZE: begin
                if (stop_ev || !en) begin
                    m_phase = M_COOL;
                    m_secs  = 0;
                end else if (tick) begin
                    m_secs++;
                    if (m_secs == SNZ) start_ring();
                end
            end
            M_COOL: if (tick) begin
                m_secs++;
                if (m_secs == CD) m_phase = M_IDLE;
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    function automatic int exp_buzzer();
        if (m_phase != M_RING) return 0;
        return (((m_cyc - m_ring_start) / BHP) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic check_all(input string pfx);
        check_eq({pfx, "_ringing"},  int'(u_if.ringing),     (m_phase == M_RING)   ? 1 : 0);
        check_eq({pfx, "_snoozing"}, int'(u_if.snoozing),    (m_phase == M_SNOOZE) ? 1 : 0);
        check_eq({pfx, "_clear"},    int'(u_if.clear_alarm), (m_phase != M_IDLE)   ? 1 : 0);
        check_eq({pfx, "_left"},     int'(u_if.snooze_left), m_left);
        check_eq({pfx, "_buzzer"},   int'(u_if.buzzer),      exp_buzzer());
    endtask

    initial begin
        int tcnt;
        int resets_done;
        bit tick, on, en, stop, snz;
        tcnt        = 0;
        resets_done = 0;
        m_cyc       = 0;
        m_ring_start = 0;
        en = 1; on = 0; stop = 0; snz = 0;
        rst_n = 1'b0;
        u_if.tick_1hz   = 1'b0;
        u_if.alarm_on   = 1'b0;
        u_if.alarm_en   = 1'b1;
        u_if.stop_btn   = 1'b0;
        u_if.snooze_btn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            check_all("run");

            if (i > 200 && resets_done < 3 && m_phase == M_RING && $urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("async_rst");
                resets_done++;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                continue;
            end

            tick = (tcnt == 9);
            tcnt = (tcnt + 1) % 10;
            if (en) en = ($urandom_range(0, 199) != 0);
            else    en = ($urandom_range(0, 19) == 0);
            on = ($urandom_range(0, 14) == 0);
            if (!stop && !snz && $urandom_range(0, 99) == 0) begin
                stop = 1; snz = 1;
            end else begin
                if ($urandom_range(0, 39) == 0) stop = !stop;
                if ($urandom_range(0, 11) == 0) snz = !snz;
            end
            u_if.tick_1hz   = tick;
            u_if.alarm_on   = on;
            u_if.alarm_en   = en;
            u_if.stop_btn   = stop;
            u_if.snooze_btn = snz;

            @(posedge clk);
            model_step(tick, on, en, stop, snz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
